// File: rtl/imem_loader.sv
// Streams big-endian program bytes into instruction memory, one 32-bit word
// at a time. The core is enabled only once the whole image has been written.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              core_ena,
    output logic [7:0]        checksum
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W:0]   idx_d;
    logic [1:0]        byte_q;
    logic [23:0]       word_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [7:0]        sum_q;

    // Index is one bit wider than the address so a full-memory load
    // terminates instead of wrapping back to address 0.
    assign idx_d = idx_q + (ADDR_W+1)'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            sum_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        count_q <= word_count;
                        idx_q   <= '0;
                        byte_q  <= '0;
                        sum_q   <= '0;
                        state_q <= (word_count == '0) ? DONE : RECV;
                    end
                end
                RECV: begin
                    if (in_valid) begin
                        sum_q  <= sum_q + in_data;
                        word_q <= {word_q[15:0], in_data};
                        byte_q <= byte_q + 2'd1;
                        if (byte_q == 2'd3) begin
                            wdata_q <= {word_q, in_data};
                            addr_q  <= idx_q[ADDR_W-1:0];
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    idx_q   <= idx_d;
                    state_q <= (idx_d < count_q) ? RECV : DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == RECV);
    assign mem_we    = (state_q == WRITE);
    assign busy      = (state_q == RECV) || (state_q == WRITE);
    assign done      = (state_q == DONE);
    assign core_ena  = (state_q == DONE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign checksum  = sum_q;

endmodule
